uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral sitting downstream of the system bridge, alongside the two timers. The bridge decodes processor stores and loads into word-addressed register accesses. The block buffers up to four bytes in a FIFO and serialises them 8N1 on `tx`. Its `IRQ` output feeds one of the spare `HWInt` lines.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Register bus between the system bridge and the UART transmitter.
// Carries a word address plus a write strobe, write data and combinational read data.
interface uart_tx_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, WE, Din, input Dout);
  modport slave  (input Addr, WE, Din, output Dout);
endinterface

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO.
// Registers: DATA, STATUS, CTRL, DIV. A level IRQ is raised when the FIFO drains.
module uart_tx #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       IRQ,
  output logic       tx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0][7:0]  r_fifo;
  logic [1:0]       r_wptr, r_rptr;
  logic [2:0]       r_count;
  logic             r_ovf, r_irqp, r_en, r_irqen;
  logic [15:0]      r_div, r_timer;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitidx;

  logic             w_pop, w_bit_end, w_full, w_empty;
  logic             w_push, w_push_ok, w_wr_stat, w_wr_ctrl, w_wr_div, w_irq_set;
  logic [15:0]      w_reload;
  logic [1:0]       w_sel;
  logic             w_unused;

  assign w_sel     = bus.Addr[3:2];
  assign w_push    = bus.WE && (w_sel == 2'd0);
  assign w_wr_stat = bus.WE && (w_sel == 2'd1);
  assign w_wr_ctrl = bus.WE && (w_sel == 2'd2);
  assign w_wr_div  = bus.WE && (w_sel == 2'd3);
  assign w_full    = (r_count == 3'(FIFO_DEPTH));
  assign w_empty   = (r_count == 3'd0);
  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_bit_end = (r_timer == 16'd0);
  assign w_reload  = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_irq_set = (r_state == S_STOP) && w_bit_end && w_empty;
  assign IRQ       = r_irqp & r_irqen;
  assign w_unused  = ^{bus.Din[31:16], bus.Addr[31:4]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    tx          = 1'b1;
    case (r_state)
      S_IDLE: if (r_en && !w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        tx = r_shift[0];
        if (w_bit_end && r_bitidx == 3'd7) w_state_nxt = S_STOP;
      end
      S_STOP: if (w_bit_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timer and shifter; the divisor is sampled only on reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer  <= '0;
      r_shift  <= '0;
      r_bitidx <= '0;
    end else if (w_pop) begin
      r_shift  <= r_fifo[r_rptr];
      r_timer  <= w_reload;
      r_bitidx <= '0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_timer <= w_reload;
        if (r_state == S_DATA) begin
          r_shift  <= {1'b0, r_shift[7:1]};
          r_bitidx <= r_bitidx + 3'd1;
        end
      end else begin
        r_timer <= r_timer - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fifo  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wptr] <= bus.Din[7:0];
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      r_count <= r_count + 3'(w_push_ok) - 3'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf   <= 1'b0;
      r_irqp  <= 1'b0;
      r_en    <= 1'b0;
      r_irqen <= 1'b0;
      r_div   <= DEFAULT_DIV;
    end else begin
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      else if (w_wr_stat)       r_ovf <= 1'b0;
      // Drain event beats a coincident clear
      if (w_irq_set)                   r_irqp <= 1'b1;
      else if (w_wr_ctrl || w_push)    r_irqp <= 1'b0;
      if (w_wr_ctrl) begin
        r_en    <= bus.Din[0];
        r_irqen <= bus.Din[1];
      end
      if (w_wr_div) r_div <= bus.Din[15:0];
    end
  end

  always_comb begin
    bus.Dout = '0;
    case (w_sel)
      2'd1:    bus.Dout = {24'd0, r_irqp, r_ovf, r_count, w_empty, w_full, r_state != S_IDLE};
      2'd2:    bus.Dout = {30'd0, r_irqen, r_en};
      2'd3:    bus.Dout = {16'd0, r_div};
      default: bus.Dout = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: register map, frame waveforms, FIFO overflow,
// interrupt behaviour, asynchronous reset mid-frame and DIV=0.
`timescale 1ns/100ps
module tb_uart_tx;
  logic clk, reset, IRQ, tx;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rdv;

  uart_tx_if bus ();

  uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .IRQ(IRQ), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = {28'd0, a};
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk); #1;
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = {28'd0, a};
    #1;
    d = bus.Dout;
  endtask

  // Called in the first START cycle; returns in the IDLE cycle after STOP
  task automatic frame(input string tag, input logic [7:0] d, input int div);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < div; c++) begin
        chk($sformatf("%s bit%0d cyc%0d", tag, i, c), {31'd0, tx}, {31'd0, bits[i]});
        tick();
      end
  endtask

  initial begin
    bus.Addr = '0; bus.WE = 1'b0; bus.Din = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    tick();

    rd(A_STAT, rdv); chk("reset STATUS", rdv, 32'h04);
    rd(A_CTRL, rdv); chk("reset CTRL", rdv, 32'h0);
    rd(A_DIV, rdv);  chk("reset DIV", rdv, 32'h10);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset IRQ", {31'd0, IRQ}, 32'd0);

    // Single frame 0xA5 at DIV=4
    wr(A_DIV, 32'd4);
    wr(A_CTRL, 32'd1);
    rd(A_DIV, rdv); chk("DIV readback", rdv, 32'd4);
    wr(A_DATA, 32'hFFFF_FFA5);
    tick();
    rd(A_STAT, rdv); chk("busy in frame", rdv & 32'h1, 32'h1);
    frame("A5", 8'hA5, 4);
    rd(A_STAT, rdv); chk("idle after A5", rdv, 32'h84);

    // Overflow with transmit disabled
    wr(A_CTRL, 32'd0);
    wr(A_DATA, 32'h11); wr(A_DATA, 32'h22); wr(A_DATA, 32'h33);
    wr(A_DATA, 32'h44); wr(A_DATA, 32'h55);
    rd(A_STAT, rdv); chk("full+ovf", rdv, 32'h62);
    chk("tx idle disabled", {31'd0, tx}, 32'd1);
    wr(A_STAT, 32'hFFFF_FFFF);
    rd(A_STAT, rdv); chk("ovf cleared", rdv, 32'h22);

    wr(A_CTRL, 32'd1);
    tick();
    frame("B0", 8'h11, 4);
    rd(A_STAT, rdv); chk("gap1 status", rdv, 32'h18);
    chk("gap1 tx", {31'd0, tx}, 32'd1);
    tick();
    frame("B1", 8'h22, 4);
    rd(A_STAT, rdv); chk("gap2 status", rdv, 32'h10);
    tick();
    frame("B2", 8'h33, 4);
    rd(A_STAT, rdv); chk("gap3 status", rdv, 32'h08);
    tick();
    frame("B3", 8'h44, 4);
    rd(A_STAT, rdv); chk("drained status", rdv, 32'h84);
    repeat (8) tick();
    chk("no 5th frame tx", {31'd0, tx}, 32'd1);
    rd(A_STAT, rdv); chk("no 5th frame status", rdv, 32'h84);

    // Interrupt enabled
    wr(A_CTRL, 32'd3);
    chk("IRQ cleared by CTRL", {31'd0, IRQ}, 32'd0);
    rd(A_STAT, rdv); chk("irqp cleared", rdv, 32'h04);
    wr(A_DATA, 32'h5A);
    tick();
    chk("IRQ low in frame", {31'd0, IRQ}, 32'd0);
    frame("C", 8'h5A, 4);
    chk("IRQ after STOP", {31'd0, IRQ}, 32'd1);
    wr(A_CTRL, 32'd3);
    chk("IRQ dropped", {31'd0, IRQ}, 32'd0);
    wr(A_CTRL, 32'd1);
    wr(A_DATA, 32'h0F);
    tick();
    frame("D", 8'h0F, 4);
    chk("IRQ masked", {31'd0, IRQ}, 32'd0);
    rd(A_STAT, rdv); chk("irqp set masked", rdv, 32'h84);

    // Async reset in the middle of DATA bits (two zero bytes queued)
    wr(A_DATA, 32'h00);
    wr(A_DATA, 32'h00);
    repeat (5) tick();
    chk("tx low in DATA", {31'd0, tx}, 32'd0);
    rd(A_STAT, rdv); chk("mid-frame status", rdv, 32'h09);
    #2 reset = 1'b0;
    #1 chk("async reset tx", {31'd0, tx}, 32'd1);
    rd(A_STAT, rdv); chk("reset status", rdv, 32'h04);
    @(negedge clk) reset = 1'b1;
    tick();
    begin
      int lows = 0;
      for (int i = 0; i < 50; i++) begin
        if (tx !== 1'b1) lows++;
        tick();
      end
      chk("no frames after reset", lows, 32'd0);
    end
    rd(A_DIV, rdv); chk("DIV after reset", rdv, 32'h10);

    // DIV=0 behaves as one cycle per bit
    wr(A_DIV, 32'd0);
    wr(A_CTRL, 32'd1);
    rd(A_DIV, rdv); chk("DIV0 readback", rdv, 32'd0);
    wr(A_DATA, 32'h3C);
    tick();
    frame("E", 8'h3C, 1);
    rd(A_STAT, rdv); chk("DIV0 done", rdv, 32'h84);
    chk("DIV0 tx idle", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
